// File: rtl/bch_t2_serial_decoder_pkg.sv
// Shared types and GF(2^m) helpers for the t=2 serial BCH decoder.
// Field helpers take the degree and primitive polynomial as arguments so one package serves every M.
package bch_t2_serial_decoder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYND,
      ST_SOLVE,
      ST_CHIEN,
      ST_DONE
   } state_t;

   localparam int GF_W = 8;

   // Shift-and-add multiply; poly carries bit m, so one xor clears the overflow bit.
   function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                             input logic [GF_W-1:0] b,
                                             input int m,
                                             input logic [GF_W:0] poly);
      logic [GF_W:0] p;
      logic [GF_W:0] top;
      p   = '0;
      top = 9'd1 << m;
      for (int i = GF_W - 1; i >= 0; i--) begin
         if (i < m) begin
            p = p << 1;
            if ((p & top) != '0) p = p ^ poly;
            if (b[i]) p = p ^ {1'b0, a};
         end
      end
      return p[GF_W-1:0];
   endfunction

   function automatic logic [GF_W-1:0] gf_sq(input logic [GF_W-1:0] a,
                                            input int m,
                                            input logic [GF_W:0] poly);
      return gf_mul(a, a, m, poly);
   endfunction

   function automatic logic [GF_W-1:0] gf_pow(input int e,
                                             input int m,
                                             input logic [GF_W:0] poly);
      logic [GF_W-1:0] r;
      r = 8'd1;
      for (int i = 0; i < 256; i++) begin
         if (i < e) r = gf_mul(r, 8'd2, m, poly);
      end
      return r;
   endfunction

endpackage

// File: rtl/bch_t2_serial_decoder_if.sv
// Stream handshake bundle for the t=2 serial BCH decoder.
// master = upstream/downstream side, slave = decoder side.
interface bch_t2_serial_decoder_if #(
   parameter int N = 15,
   parameter int K = 7
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_codeword;
   logic         out_valid;
   logic         out_ready;
   logic [K-1:0] out_data;
   logic         out_err_detected;
   logic         out_err_corrected;
   logic [1:0]   out_err_count;
   logic         out_uncorrectable;

   modport master (
      output in_valid, in_codeword, out_ready,
      input  in_ready, out_valid, out_data, out_err_detected,
             out_err_corrected, out_err_count, out_uncorrectable
   );

   modport slave (
      input  in_valid, in_codeword, out_ready,
      output in_ready, out_valid, out_data, out_err_detected,
             out_err_corrected, out_err_count, out_uncorrectable
   );
endinterface

// File: rtl/bch_t2_serial_decoder_gf_mul.sv
// Combinational M-bit GF(2^M) multiplier reduced by PRIM_POLY.
module bch_t2_serial_decoder_gf_mul #(
   parameter int         M         = 4,
   parameter logic [8:0] PRIM_POLY = 9'h13
) (
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
   output logic [M-1:0] p
);

   logic [M-1:0] acc;

   always_comb begin
      acc = '0;
      for (int i = M - 1; i >= 0; i--) begin
         acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? PRIM_POLY[M-1:0] : '0);
         if (b[i]) acc = acc ^ a;
      end
   end

   assign p = acc;

endmodule

// File: rtl/bch_t2_serial_decoder.sv
// Sequential double-error-correcting binary BCH decoder over GF(2^M), N = 2^M-1.
// Optional BCH_STATS_EN adds saturating corrected/uncorrectable counters with stat_clear.
//
//   state    | meaning
//   ST_IDLE  | in_ready high, waiting for a codeword
//   ST_SYND  | N cycles of Horner syndrome accumulation (S1, S3), MSB first
//   ST_SOLVE | one cycle: build scaled Peterson locator L0 + L1 x + L2 x^2
//   ST_CHIEN | N cycles of Chien search, flipping located data bits
//   ST_DONE  | register result, hold out_valid until out_ready
module bch_t2_serial_decoder
   import bch_t2_serial_decoder_pkg::*;
#(
   parameter int         M         = 4,
   parameter int         K         = 7,
   parameter logic [8:0] PRIM_POLY = 9'h13
) (
   input  logic                  clk,
   input  logic                  rst,
   bch_t2_serial_decoder_if.slave bus
`ifdef BCH_STATS_EN
   ,
   input  logic                  stat_clear,
   output logic [15:0]           stat_corrected,
   output logic [15:0]           stat_uncorrectable
`endif
);

   localparam int N = (1 << M) - 1;
   localparam int P = N - K;
   localparam logic [M-1:0] LAST = M'(N - 1);

   localparam logic [7:0] A1_W  = gf_pow(1, M, PRIM_POLY);
   localparam logic [7:0] A3_W  = gf_mul(gf_sq(A1_W, M, PRIM_POLY), A1_W, M, PRIM_POLY);
   localparam logic [7:0] AN1_W = gf_pow(N - 1, M, PRIM_POLY);
   localparam logic [7:0] AN2_W = gf_pow(N - 2, M, PRIM_POLY);
   localparam logic [M-1:0] A1  = A1_W[M-1:0];
   localparam logic [M-1:0] A3  = A3_W[M-1:0];
   localparam logic [M-1:0] AN1 = AN1_W[M-1:0];
   localparam logic [M-1:0] AN2 = AN2_W[M-1:0];

   state_t       state_q, state_d;
   logic [M-1:0] cnt_q, cnt_d;
   logic [N-1:0] raw_q, raw_d;
   logic [K-1:0] work_q, work_d;
   logic [M-1:0] s1_q, s1_d;
   logic [M-1:0] s3_q, s3_d;
   logic [M-1:0] l0_q, l0_d;
   logic [M-1:0] t1_q, t1_d;
   logic [M-1:0] t2_q, t2_d;
   logic [1:0]   deg_q, deg_d;
   logic         bad_q, bad_d;
   logic         det_q, det_d;
   logic         srch_q, srch_d;
   logic [1:0]   roots_q, roots_d;

   logic         out_valid_q, out_valid_d;
   logic [K-1:0] out_data_q, out_data_d;
   logic         out_det_q, out_det_d;
   logic         out_corr_q, out_corr_d;
   logic [1:0]   out_cnt_q, out_cnt_d;
   logic         out_unc_q, out_unc_d;

   logic [M-1:0] m0_a, m0_b, m0_p;
   logic [M-1:0] m1_a, m1_b, m1_p;
   logic [M-1:0] idx;
   logic [M-1:0] r_ext;
   logic         root;
   logic         unc;
   logic         in_ready;

   bch_t2_serial_decoder_gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_mul0 (
      .a (m0_a),
      .b (m0_b),
      .p (m0_p)
   );

   bch_t2_serial_decoder_gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_mul1 (
      .a (m1_a),
      .b (m1_b),
      .p (m1_p)
   );

   // Multipliers are time-shared: syndrome update, S1^2/S1^3 in SOLVE, Chien stepping.
   always_comb begin
      m0_a = s1_q;
      m0_b = A1;
      case (state_q)
         ST_SOLVE: begin
            m0_a = s1_q;
            m0_b = s1_q;
         end
         ST_CHIEN: begin
            m0_a = t1_q;
            m0_b = AN1;
         end
         default: ;
      endcase
   end

   always_comb begin
      m1_a = s3_q;
      m1_b = A3;
      case (state_q)
         ST_SOLVE: begin
            m1_a = m0_p;
            m1_b = s1_q;
         end
         ST_CHIEN: begin
            m1_a = t2_q;
            m1_b = AN2;
         end
         default: ;
      endcase
   end

   assign in_ready = (state_q == ST_IDLE) && !rst;
   assign idx      = LAST - cnt_q;
   assign r_ext    = {{(M-1){1'b0}}, raw_q[cnt_q]};
   assign root     = srch_q && ((l0_q ^ t1_q ^ t2_q) == '0);
   assign unc      = bad_q || (roots_q != deg_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      raw_d       = raw_q;
      work_d      = work_q;
      s1_d        = s1_q;
      s3_d        = s3_q;
      l0_d        = l0_q;
      t1_d        = t1_q;
      t2_d        = t2_q;
      deg_d       = deg_q;
      bad_d       = bad_q;
      det_d       = det_q;
      srch_d      = srch_q;
      roots_d     = roots_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_det_d   = out_det_q;
      out_corr_d  = out_corr_q;
      out_cnt_d   = out_cnt_q;
      out_unc_d   = out_unc_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && in_ready) begin
               raw_d   = bus.in_codeword;
               work_d  = bus.in_codeword[N-1:P];
               s1_d    = '0;
               s3_d    = '0;
               cnt_d   = LAST;
               state_d = ST_SYND;
            end
         end

         ST_SYND: begin
            s1_d = m0_p ^ r_ext;
            s3_d = m1_p ^ r_ext;
            if (cnt_q == '0) state_d = ST_SOLVE;
            else             cnt_d   = cnt_q - 1'b1;
         end

         ST_SOLVE: begin
            det_d   = (s1_q != '0) || (s3_q != '0);
            bad_d   = (s1_q == '0) && (s3_q != '0);
            roots_d = '0;
            cnt_d   = LAST;
            state_d = ST_CHIEN;
            if (s1_q == '0) begin
               // Covers both the clean word and S1=0,S3!=0; search disabled so nothing flips.
               l0_d   = '0;
               t1_d   = '0;
               t2_d   = '0;
               deg_d  = 2'd0;
               srch_d = 1'b0;
            end else if (s3_q == m1_p) begin
               l0_d   = {{(M-1){1'b0}}, 1'b1};
               t1_d   = s1_q;
               t2_d   = '0;
               deg_d  = 2'd1;
               srch_d = 1'b1;
            end else begin
               l0_d   = s1_q;
               t1_d   = m0_p;
               t2_d   = s3_q ^ m1_p;
               deg_d  = 2'd2;
               srch_d = 1'b1;
            end
         end

         ST_CHIEN: begin
            t1_d = m0_p;
            t2_d = m1_p;
            if (root && roots_q != 2'd3) roots_d = roots_q + 2'd1;
            for (int b = 0; b < K; b++) begin
               if (root && idx == M'(b + P)) work_d[b] = ~work_q[b];
            end
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - 1'b1;
         end

         ST_DONE: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = unc ? raw_q[N-1:P] : work_q;
               out_det_d   = det_q;
               out_corr_d  = det_q && !unc;
               out_cnt_d   = unc ? 2'd0 : roots_q;
               out_unc_d   = unc;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         raw_q       <= '0;
         work_q      <= '0;
         s1_q        <= '0;
         s3_q        <= '0;
         l0_q        <= '0;
         t1_q        <= '0;
         t2_q        <= '0;
         deg_q       <= '0;
         bad_q       <= 1'b0;
         det_q       <= 1'b0;
         srch_q      <= 1'b0;
         roots_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_det_q   <= 1'b0;
         out_corr_q  <= 1'b0;
         out_cnt_q   <= '0;
         out_unc_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         raw_q       <= raw_d;
         work_q      <= work_d;
         s1_q        <= s1_d;
         s3_q        <= s3_d;
         l0_q        <= l0_d;
         t1_q        <= t1_d;
         t2_q        <= t2_d;
         deg_q       <= deg_d;
         bad_q       <= bad_d;
         det_q       <= det_d;
         srch_q      <= srch_d;
         roots_q     <= roots_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_det_q   <= out_det_d;
         out_corr_q  <= out_corr_d;
         out_cnt_q   <= out_cnt_d;
         out_unc_q   <= out_unc_d;
      end
   end

   assign bus.in_ready          = in_ready;
   assign bus.out_valid         = out_valid_q;
   assign bus.out_data          = out_data_q;
   assign bus.out_err_detected  = out_det_q;
   assign bus.out_err_corrected = out_corr_q;
   assign bus.out_err_count     = out_cnt_q;
   assign bus.out_uncorrectable = out_unc_q;

`ifdef BCH_STATS_EN
   logic [15:0] stat_corr_q, stat_corr_d;
   logic [15:0] stat_unc_q, stat_unc_d;
   logic        done_hs;

   assign done_hs = (state_q == ST_DONE) && out_valid_q && bus.out_ready;

   always_comb begin
      stat_corr_d = stat_corr_q;
      stat_unc_d  = stat_unc_q;
      if (stat_clear) begin
         stat_corr_d = '0;
         stat_unc_d  = '0;
      end else if (done_hs) begin
         if (out_corr_q && stat_corr_q != 16'hFFFF) stat_corr_d = stat_corr_q + 16'd1;
         if (out_unc_q && stat_unc_q != 16'hFFFF)   stat_unc_d  = stat_unc_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_corr_q <= '0;
         stat_unc_q  <= '0;
      end else begin
         stat_corr_q <= stat_corr_d;
         stat_unc_q  <= stat_unc_d;
      end
   end

   assign stat_corrected     = stat_corr_q;
   assign stat_uncorrectable = stat_unc_q;
`endif

endmodule

// File: tb/tb_bch_t2_serial_decoder.sv
// Bench for the t=2 serial BCH(15,7) decoder: directed spec words plus random encoded words
// with 0..3 injected errors, checked against a brute-force nearest-codeword reference.
module tb_bch_t2_serial_decoder;

   localparam int M   = 4;
   localparam int K   = 7;
   localparam int N   = 15;
   localparam int LAT = 2 * N + 2;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [3:0] alog [15];

   always #5 clk = ~clk;

   bch_t2_serial_decoder_if #(.N(N), .K(K)) bus ();

`ifdef BCH_STATS_EN
   logic        stat_clear = 1'b0;
   logic [15:0] stat_corrected;
   logic [15:0] stat_uncorrectable;
`endif

   bch_t2_serial_decoder #(.M(M), .K(K), .PRIM_POLY(9'h13)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef BCH_STATS_EN
      ,
      .stat_clear         (stat_clear),
      .stat_corrected     (stat_corrected),
      .stat_uncorrectable (stat_uncorrectable)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // {S1,S3} = {r(a), r(a^3)} from the power table.
   function automatic logic [7:0] syn(input logic [14:0] w);
      logic [3:0] s1;
      logic [3:0] s3;
      s1 = '0;
      s3 = '0;
      for (int i = 0; i < 15; i++) begin
         if (w[i]) begin
            s1 = s1 ^ alog[i];
            s3 = s3 ^ alog[(3 * i) % 15];
         end
      end
      return {s1, s3};
   endfunction

   function automatic logic [14:0] encode(input logic [6:0] d);
      logic [14:0] r;
      r = {d, 8'h00};
      for (int i = 14; i >= 8; i--) begin
         if (r[i]) r = r ^ (15'h01D1 << (i - 8));
      end
      return {d, r[7:0]};
   endfunction

   task automatic ref_decode(input logic [14:0] w, output logic [6:0] d, output logic det,
                             output logic corr, output logic [1:0] cnt, output logic unc);
      logic        found;
      logic [14:0] c;
      found = 1'b0;
      c     = w;
      det   = (syn(w) != 8'h00);
      corr  = 1'b0;
      cnt   = 2'd0;
      unc   = 1'b0;
      d     = w[14:8];
      if (det) begin
         for (int i = 0; i < 15; i++) begin
            if (!found && syn(w ^ (15'd1 << i)) == 8'h00) begin
               found = 1'b1;
               c     = w ^ (15'd1 << i);
               cnt   = 2'd1;
            end
         end
         for (int i = 0; i < 15; i++) begin
            for (int j = i + 1; j < 15; j++) begin
               if (!found && syn(w ^ (15'd1 << i) ^ (15'd1 << j)) == 8'h00) begin
                  found = 1'b1;
                  c     = w ^ (15'd1 << i) ^ (15'd1 << j);
                  cnt   = 2'd2;
               end
            end
         end
         if (found) begin
            corr = 1'b1;
            d    = c[14:8];
         end else begin
            unc = 1'b1;
         end
      end
   endtask

   task automatic put(input logic [14:0] w);
      int t;
      t = 0;
      while (!bus.in_ready && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.in_valid    = 1'b1;
      bus.in_codeword = w;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic get(input logic [14:0] w, input int hold, input string tag);
      int         lat;
      logic [6:0] d;
      logic [6:0] d0;
      logic       det, corr, unc;
      logic [1:0] cnt;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.out_valid && lat < 200);
      chk({tag, "_latency"}, 32'(lat), 32'(LAT));
      ref_decode(w, d, det, corr, cnt, unc);
      chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
      chk({tag, "_detected"}, 32'(bus.out_err_detected), 32'(det));
      chk({tag, "_corrected"}, 32'(bus.out_err_corrected), 32'(corr));
      chk({tag, "_count"}, 32'(bus.out_err_count), 32'(cnt));
      chk({tag, "_uncorr"}, 32'(bus.out_uncorrectable), 32'(unc));
      d0 = bus.out_data;
      for (int c = 0; c < hold; c++) begin
         bus.in_valid    = 1'b1;
         bus.in_codeword = 15'h7FFF;
         @(posedge clk);
         #1;
         chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         chk({tag, "_hold_data"}, 32'(bus.out_data), 32'(d0));
         chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [14:0] w;
      logic [14:0] e;
      logic [3:0]  a;
      int          ne;

      a = 4'd1;
      for (int i = 0; i < 15; i++) begin
         alog[i] = a;
         a = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
      end

      bus.in_valid    = 1'b0;
      bus.in_codeword = '0;
      bus.out_ready   = 1'b0;
      rst             = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_data", 32'(bus.out_data), 32'd0);
      chk("reset_detected", 32'(bus.out_err_detected), 32'd0);
      chk("reset_corrected", 32'(bus.out_err_corrected), 32'd0);
      chk("reset_count", 32'(bus.out_err_count), 32'd0);
      chk("reset_uncorr", 32'(bus.out_uncorrectable), 32'd0);
      rst = 1'b0;
      #1;
      chk("release_in_ready", 32'(bus.in_ready), 32'd1);

      put(15'h01D1);
      get(15'h01D1, 0, "clean");
      chk("clean_data_const", 32'(bus.out_data), 32'h01);

      for (int i = 0; i < 15; i++) begin
         w = 15'h01D1 ^ (15'd1 << i);
         put(w);
         get(w, 0, "single");
         chk("single_count_const", 32'(bus.out_err_count), 32'd1);
      end

      put(15'h4001);
      get(15'h4001, 0, "double_0_14");
      chk("double_0_14_count_const", 32'(bus.out_err_count), 32'd2);
      put(15'h0220);
      get(15'h0220, 0, "double_5_9");
      chk("double_5_9_data_const", 32'(bus.out_data), 32'h00);

      put(15'h0013);
      get(15'h0013, 0, "s1zero");
      chk("s1zero_uncorr_const", 32'(bus.out_uncorrectable), 32'd1);

      w = encode(7'h5A) ^ 15'h0008;
      put(w);
      get(w, 20, "backpressure");

      put(encode(7'h33));
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_release_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_release_out_valid", 32'(bus.out_valid), 32'd0);
      w = encode(7'h33) ^ 15'h0900;
      put(w);
      get(w, 0, "after_rst");

      for (int n = 0; n < 40; n++) begin
         w  = encode(7'($urandom()));
         ne = int'($urandom_range(0, 3));
         e  = '0;
         while ($countones(e) < ne) e[$urandom_range(0, 14)] = 1'b1;
         w = w ^ e;
         put(w);
         get(w, int'($urandom_range(0, 2)), "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
